// File: rtl/cpu86_bpu_callret_det_if.sv
// cpu86_bpu_callret_det_if: byte-stream, return-stack and prediction signal bundle.
interface cpu86_bpu_callret_det_if #(
    parameter int unsigned IPW = 16
);
    logic           in_vld;
    logic           in_rdy;
    logic [7:0]     in_data;
    logic           in_first;
    logic [IPW-1:0] in_ip;
    logic           lifo_push_vld;
    logic [IPW-1:0] lifo_push_data;
    logic           lifo_pop_vld;
    logic           lifo_pop_ack;
    logic [IPW-1:0] lifo_pop_data;
    logic           pred_vld;
    logic           pred_ack;
    logic [IPW-1:0] pred_target;
    logic           pred_kind;

    // Detector view
    modport slave (
        input  in_vld, in_data, in_first, in_ip, lifo_pop_vld, lifo_pop_data, pred_ack,
        output in_rdy, lifo_push_vld, lifo_push_data, lifo_pop_ack, pred_vld, pred_target, pred_kind
    );

    // Decoder / return stack / prediction consumer view
    modport master (
        output in_vld, in_data, in_first, in_ip, lifo_pop_vld, lifo_pop_data, pred_ack,
        input  in_rdy, lifo_push_vld, lifo_push_data, lifo_pop_ack, pred_vld, pred_target, pred_kind
    );
endinterface

// File: rtl/cpu86_bpu_callret_det.sv
// cpu86_bpu_callret_det: recognises near CALL rel16 (E8), RET (C3) and RET imm16 (C2)
// in the decoder byte stream, pushes/pops the return-address stack and emits predictions.
// Optional statistics counters are built when CPU86_BPU_CALLRET_STATS_EN is defined.
module cpu86_bpu_callret_det #(
    parameter int unsigned IPW = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    cpu86_bpu_callret_det_if.slave bus,
    output logic [15:0]            stat_calls,
    output logic [15:0]            stat_rets,
    output logic [15:0]            stat_miss
);
    localparam int unsigned STW     = 16;
    localparam logic [7:0]  OP_CALL = 8'hE8;
    localparam logic [7:0]  OP_RET  = 8'hC3;
    localparam logic [7:0]  OP_RETN = 8'hC2;

    typedef enum logic [2:0] {
        IDLE,
        CALL_LO,
        CALL_HI,
        EMIT_CALL,
        EMIT_RET,
        SKIP_LO,
        SKIP_HI
    } state_t;

    state_t         state, state_n;
    logic           skip_q, skip_n;
    logic [IPW-1:0] ret_ip_q, ret_ip_n;
    logic [7:0]     disp_lo_q, disp_lo_n;
    logic           pred_vld_q, pred_vld_n;
    logic [IPW-1:0] pred_target_q, pred_target_n;
    logic           pred_kind_q, pred_kind_n;
    logic           push_q, push_n;
    logic           in_rdy_q, in_rdy_n;
    logic           pop_ack_c;
    logic           accept_c;
    logic           decode_c;

    // State and registered-output update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            skip_q        <= 1'b0;
            ret_ip_q      <= '0;
            disp_lo_q     <= '0;
            pred_vld_q    <= 1'b0;
            pred_target_q <= '0;
            pred_kind_q   <= 1'b0;
            push_q        <= 1'b0;
            in_rdy_q      <= 1'b1;
        end else begin
            state         <= state_n;
            skip_q        <= skip_n;
            ret_ip_q      <= ret_ip_n;
            disp_lo_q     <= disp_lo_n;
            pred_vld_q    <= pred_vld_n;
            pred_target_q <= pred_target_n;
            pred_kind_q   <= pred_kind_n;
            push_q        <= push_n;
            in_rdy_q      <= in_rdy_n;
        end
    end

    // Next-state decode; a first byte inside CALL/SKIP restarts opcode decode in the same cycle.
    // RET stack status is snapshotted when the opcode is accepted; only this block moves the stack.
    always_comb begin
        state_n       = state;
        skip_n        = skip_q;
        ret_ip_n      = ret_ip_q;
        disp_lo_n     = disp_lo_q;
        pred_vld_n    = pred_vld_q;
        pred_target_n = pred_target_q;
        pred_kind_n   = pred_kind_q;
        push_n        = 1'b0;
        pop_ack_c     = 1'b0;
        decode_c      = 1'b0;
        accept_c      = bus.in_vld & in_rdy_q;

        case (state)
            IDLE: begin
                if (accept_c && bus.in_first) decode_c = 1'b1;
            end
            CALL_LO: begin
                if (accept_c) begin
                    if (bus.in_first) begin
                        decode_c = 1'b1;
                    end else begin
                        disp_lo_n = bus.in_data;
                        state_n   = CALL_HI;
                    end
                end
            end
            CALL_HI: begin
                if (accept_c) begin
                    if (bus.in_first) begin
                        decode_c = 1'b1;
                    end else begin
                        pred_target_n = ret_ip_q + IPW'({bus.in_data, disp_lo_q});
                        pred_kind_n   = 1'b0;
                        pred_vld_n    = 1'b1;
                        push_n        = 1'b1;
                        state_n       = EMIT_CALL;
                    end
                end
            end
            EMIT_CALL: begin
                if (bus.pred_ack) begin
                    pred_vld_n = 1'b0;
                    state_n    = IDLE;
                end
            end
            EMIT_RET: begin
                if (pred_vld_q) begin
                    if (bus.pred_ack) begin
                        pop_ack_c  = 1'b1;
                        pred_vld_n = 1'b0;
                        state_n    = skip_q ? SKIP_LO : IDLE;
                    end
                end else begin
                    state_n = skip_q ? SKIP_LO : IDLE;
                end
            end
            SKIP_LO: begin
                if (accept_c) begin
                    if (bus.in_first) decode_c = 1'b1;
                    else              state_n  = SKIP_HI;
                end
            end
            SKIP_HI: begin
                if (accept_c) begin
                    if (bus.in_first) decode_c = 1'b1;
                    else              state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        if (decode_c) begin
            case (bus.in_data)
                OP_CALL: begin
                    ret_ip_n = bus.in_ip + IPW'(3);
                    state_n  = CALL_LO;
                end
                OP_RET, OP_RETN: begin
                    skip_n      = (bus.in_data == OP_RETN);
                    pred_vld_n  = bus.lifo_pop_vld;
                    pred_kind_n = 1'b1;
                    if (bus.lifo_pop_vld) pred_target_n = bus.lifo_pop_data;
                    state_n     = EMIT_RET;
                end
                default: state_n = IDLE;
            endcase
        end

        if (flush) begin
            state_n    = IDLE;
            pred_vld_n = 1'b0;
            push_n     = 1'b0;
            pop_ack_c  = 1'b0;
        end

        in_rdy_n = (state_n != EMIT_CALL) && (state_n != EMIT_RET);
    end

    // Output drive; push and pop strobes are suppressed during a flush cycle
    assign bus.in_rdy         = in_rdy_q;
    assign bus.pred_vld       = pred_vld_q;
    assign bus.pred_target    = pred_target_q;
    assign bus.pred_kind      = pred_kind_q;
    assign bus.lifo_push_vld  = push_q & ~flush;
    assign bus.lifo_push_data = ret_ip_q;
    assign bus.lifo_pop_ack   = pop_ack_c;

`ifdef CPU86_BPU_CALLRET_STATS_EN
    logic [STW-1:0] calls_q, rets_q, miss_q;
    logic           ret_evt_c, miss_evt_c;

    assign ret_evt_c  = (state == EMIT_RET) & pred_vld_q & bus.pred_ack & ~flush;
    assign miss_evt_c = (state == EMIT_RET) & ~pred_vld_q & ~flush;

    // Saturating event counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            calls_q <= '0;
            rets_q  <= '0;
            miss_q  <= '0;
        end else begin
            if (push_q && (calls_q != '1))    calls_q <= calls_q + STW'(1);
            if (ret_evt_c && (rets_q != '1))  rets_q  <= rets_q + STW'(1);
            if (miss_evt_c && (miss_q != '1)) miss_q  <= miss_q + STW'(1);
        end
    end

    assign stat_calls = calls_q;
    assign stat_rets  = rets_q;
    assign stat_miss  = miss_q;
`else
    assign stat_calls = '0;
    assign stat_rets  = '0;
    assign stat_miss  = '0;
`endif

endmodule
